// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: reads a source word, then writes it to the destination, in ascending order.
// Optional feature: define MEM_COPY_CHECKSUM_EN to add a running 32-bit sum of the copied words on port checksum.
module mem_copy_engine #(
  parameter int unsigned RAM_SIZE_BIT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             src_addr,
  input  logic [31:0]             dst_addr,
  input  logic [RAM_SIZE_BIT:0]   length,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             Address,
  output logic [31:0]             Write_data,
  output logic                    MemRead,
  output logic                    MemWrite,
  input  logic [31:0]             Read_data
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]             checksum
`endif
);

  localparam int unsigned LEN_W  = RAM_SIZE_BIT + 1;
  localparam int unsigned WADR_W = 30;
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {RAM_SIZE_BIT{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic [LEN_W-1:0]    idx_q, idx_n;
  logic [LEN_W-1:0]    len_q, len_n;
  logic [WADR_W-1:0]   src_q, src_n;
  logic [WADR_W-1:0]   dst_q, dst_n;
  logic [31:0]         data_q, data_n;
  logic                busy_n, done_n, rd_n, wr_n;
  logic [31:0]         addr_n, wdata_n;
  logic                accept;

  // Byte-offset bits of the addresses are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  // Next state, datapath and next registered outputs.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    len_n   = len_q;
    src_n   = src_q;
    dst_n   = dst_q;
    data_n  = data_q;
    accept  = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    addr_n  = '0;
    wdata_n = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          src_n   = src_addr[31:2];
          dst_n   = dst_addr[31:2];
          len_n   = (length > MAX_LEN) ? MAX_LEN : length;
          idx_n   = '0;
          state_n = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        data_n  = Read_data;
        state_n = WRITE;
      end
      WRITE: begin
        idx_n   = idx_q + LEN_W'(1);
        state_n = (idx_n == len_q) ? DONE : READ;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
    if (state_n == READ) begin
      rd_n   = 1'b1;
      addr_n = {src_n + WADR_W'(idx_n), 2'b00};
    end
    if (state_n == WRITE) begin
      wr_n    = 1'b1;
      addr_n  = {dst_n + WADR_W'(idx_n), 2'b00};
      wdata_n = data_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Address    <= '0;
      Write_data <= '0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      len_q      <= len_n;
      src_q      <= src_n;
      dst_q      <= dst_n;
      data_q     <= data_n;
      busy       <= busy_n;
      done       <= done_n;
      MemRead    <= rd_n;
      MemWrite   <= wr_n;
      Address    <= addr_n;
      Write_data <= wdata_n;
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum_n;

  // Sum of the words written; held after completion until the next accepted start.
  always_comb begin
    checksum_n = checksum;
    if (accept) begin
      checksum_n = '0;
    end else if (state_q == WRITE) begin
      checksum_n = checksum + data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else begin
      checksum <= checksum_n;
    end
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: vector table of copies plus hand-written reset, overlap and start-hold sequences.
module tb_mem_copy_engine;

  localparam int unsigned RSB       = 4;
  localparam int unsigned LW        = RSB + 1;
  localparam int unsigned MEM_WORDS = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   src_addr, dst_addr;
  logic [LW-1:0] length;
  logic          busy, done, MemRead, MemWrite;
  logic [31:0]   Address, Write_data, Read_data;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] img [MEM_WORDS];
  logic        init_req = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.RAM_SIZE_BIT(RSB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // Behavioural memory: combinational read, write committed on posedge.
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < MEM_WORDS; k++) mem[k] <= img[k];
    end else if (MemWrite) begin
      mem[Address[11:2]] <= Write_data;
    end
  end
  assign Read_data = MemRead ? mem[Address[11:2]] : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < MEM_WORDS; k++) img[k] = 32'hA000 + 32'(k);
  endtask

  task automatic load_mem();
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
  endtask

  // Launch one copy and observe it at negedges until busy drops (bounded).
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] l,
                          output int dk, output int rd, output int wr, output int dn,
                          output int bc, output logic [31:0] a1, output logic idle_ok);
    dk = -1; rd = 0; wr = 0; dn = 0; bc = 0; a1 = 32'hDEAD_BEEF; idle_ok = 1'b0;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; length = LW'($urandom);
    for (int k = 0; k < 200; k++) begin
      if (MemRead) begin
        if (rd == 1) a1 = Address;
        rd++;
      end
      if (MemWrite) wr++;
      if (done) begin
        if (dk < 0) dk = k;
        dn++;
      end
      if (!busy) begin
        idle_ok = !MemRead && !MemWrite && !done && (Address == 32'h0) && (Write_data == 32'h0);
        break;
      end
      bc++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [LW-1:0] len;
    int            exp_k;
    int            exp_n;
    int            first_idx;
    logic [31:0]   first_val;
    int            last_idx;
    logic [31:0]   last_val;
    int            past_idx;
    logic [31:0]   past_val;
    logic [31:0]   exp_rd1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          dk, rd, wr, dn, bc, cnt;
    logic [31:0] a1;
    logic        idle_ok;

    vecs[0] = '{32'h0000_0000, 32'h0000_0200, 5'd4,  8,  4, 128, 32'hA000, 131, 32'hA003, 132, 32'hA084, 32'h0000_0004};
    vecs[1] = '{32'h0000_0013, 32'h0000_0402, 5'd1,  2,  1, 256, 32'hA004, 256, 32'hA004, 257, 32'hA101, 32'h0};
    vecs[2] = '{32'h0000_0100, 32'h0000_0800, 5'd0,  0,  0, 512, 32'hA200, 512, 32'hA200, 513, 32'hA201, 32'h0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0100, 5'd20, 32, 16, 64, 32'hA000, 79,  32'hA00F, 80,  32'hA050, 32'h0000_0004};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0300, 5'd2,  4,  2, 192, 32'hA3FF, 193, 32'hA000, 194, 32'hA0C2, 32'h0000_0000};
    vecs[5] = '{32'h0000_0040, 32'h0000_0C00, 5'd16, 32, 16, 768, 32'hA010, 783, 32'hA01F, 784, 32'hA310, 32'h0000_0044};

    reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    fill_pattern();
    #12;
    check("reset_ctrl", 32'({busy, done, MemRead, MemWrite}), 32'h0);
    check("reset_addr", Address, 32'h0);
    check("reset_wdata", Write_data, 32'h0);
    @(negedge clk); reset = 1'b1;
    load_mem();
    check("idle_busy", 32'(busy), 32'h0);

    for (int v = 0; v < 6; v++) begin
      fill_pattern();
      load_mem();
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, dk, rd, wr, dn, bc, a1, idle_ok);
      check($sformatf("v%0d_done_cycle", v), 32'(dk), 32'(vecs[v].exp_k));
      check($sformatf("v%0d_reads", v), 32'(rd), 32'(vecs[v].exp_n));
      check($sformatf("v%0d_writes", v), 32'(wr), 32'(vecs[v].exp_n));
      check($sformatf("v%0d_done_pulses", v), 32'(dn), 32'h1);
      check($sformatf("v%0d_busy_cycles", v), 32'(bc), 32'(vecs[v].exp_k + 1));
      check($sformatf("v%0d_idle_outputs", v), 32'(idle_ok), 32'h1);
      check($sformatf("v%0d_first_word", v), mem[vecs[v].first_idx], vecs[v].first_val);
      check($sformatf("v%0d_last_word", v), mem[vecs[v].last_idx], vecs[v].last_val);
      check($sformatf("v%0d_past_word", v), mem[vecs[v].past_idx], vecs[v].past_val);
      if (vecs[v].exp_n >= 2) check($sformatf("v%0d_second_read_addr", v), a1, vecs[v].exp_rd1);
    end

    // Reference copy of four known words.
    fill_pattern();
    img[0] = 32'd306; img[1] = 32'd328; img[2] = 32'd738; img[3] = 32'd38;
    load_mem();
    run_copy(32'h0, 32'h200, 5'd4, dk, rd, wr, dn, bc, a1, idle_ok);
    check("ref_done_cycle", 32'(dk), 32'd8);
    check("ref_w128", mem[128], 32'd306);
    check("ref_w129", mem[129], 32'd328);
    check("ref_w130", mem[130], 32'd738);
    check("ref_w131", mem[131], 32'd38);
`ifdef MEM_COPY_CHECKSUM_EN
    check("ref_checksum", checksum, 32'd1410);
`endif

    // Overlapping forward copy smears the first word.
    fill_pattern();
    img[0] = 32'd306; img[1] = 32'd328; img[2] = 32'd738;
    load_mem();
    run_copy(32'h0, 32'h4, 5'd3, dk, rd, wr, dn, bc, a1, idle_ok);
    check("ovl_w1", mem[1], 32'd306);
    check("ovl_w2", mem[2], 32'd306);
    check("ovl_w3", mem[3], 32'd306);
    check("ovl_w4", mem[4], 32'hA004);

    // Reset right after the second write commits.
    fill_pattern();
    load_mem();
    @(negedge clk);
    src_addr = 32'h0; dst_addr = 32'h400; length = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr = 0;
    for (int k = 0; k < 50 && wr < 2; k++) begin
      if (MemWrite) wr++;
      if (wr < 2) @(negedge clk);
    end
    check("abort_saw_two_writes", 32'(wr), 32'd2);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_ctrl", 32'({busy, done, MemRead, MemWrite}), 32'h0);
    check("abort_addr", Address, 32'h0);
    check("abort_wdata", Write_data, 32'h0);
    repeat (3) @(negedge clk);
    check("abort_w256", mem[256], 32'hA000);
    check("abort_w257", mem[257], 32'hA001);
    check("abort_w258", mem[258], 32'hA102);
    reset = 1'b1;
    run_copy(32'h0, 32'h400, 5'd3, dk, rd, wr, dn, bc, a1, idle_ok);
    check("post_abort_done_cycle", 32'(dk), 32'd6);
    check("post_abort_w258", mem[258], 32'hA002);
    check("post_abort_w259", mem[259], 32'hA103);

    // start held high and re-pulsed mid-copy: exactly one copy.
    fill_pattern();
    load_mem();
    @(negedge clk);
    src_addr = 32'h20; dst_addr = 32'h600; length = 5'd3; start = 1'b1;
    @(negedge clk);
    wr = 0; dn = 0;
    for (int k = 0; k < 60; k++) begin
      if (MemWrite) wr++;
      if (done) dn++;
      if (!busy) break;
      start = (dn > 0) ? 1'b0 : (k != 3);
      @(negedge clk);
    end
    start = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    check("hold_writes", 32'(wr), 32'd3);
    check("hold_done_pulses", 32'(dn), 32'd1);
    check("hold_no_restart", 32'(cnt), 32'd0);
    check("hold_w386", mem[386], 32'hA00A);
    check("hold_w387", mem[387], 32'hA183);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
